// File: rtl/pipe_ctrl_gen.sv
// rtl/pipe_ctrl_gen.sv - pipeline stall/flush controller with redirect and stall watchdog
// Optional per-stage stall counters: define PIPE_CTRL_PERF_EN.
module pipe_ctrl_gen #(
    parameter int NSTAGES       = 5,
    parameter int XLEN          = 32,
    parameter int FLUSH_CYCLES  = 1,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NSTAGES-1:0]      stallreq,
    input  logic [NSTAGES-1:0]      flush_req,
    input  logic [NSTAGES*XLEN-1:0] flush_pc,
    output logic [NSTAGES:0]        stall,
    output logic [NSTAGES:0]        flush,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic                    stall_timeout,
    output logic [NSTAGES*32-1:0]   perf_stall_cnt
);
    localparam int KW = $clog2(NSTAGES + 1);
    localparam logic [1:0] FC_LOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]      r_state;
    logic [KW-1:0]   r_cur_k;
    logic [1:0]      r_cnt;
    logic [NSTAGES:0] r_flush;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;

    logic [KW-1:0]    w_k;
    logic [NSTAGES:0] w_stall;
    logic [KW-1:0]    w_fk;
    logic [XLEN-1:0]  w_fpc;
    logic [NSTAGES:0] w_fmask;
    logic             w_accept;

    // Stall origin is the oldest requester; everything younger holds with it.
    always_comb begin
        w_k = '0;
        for (int i = 0; i < NSTAGES; i++)
            if (stallreq[i]) w_k = KW'(i + 1);
        for (int j = 0; j <= NSTAGES; j++)
            w_stall[j] = (w_k != '0) && (KW'(j) <= w_k);
    end

    assign stall = rst ? '0 : w_stall;

    // A requester held by stall is not eligible; oldest eligible request wins.
    always_comb begin
        w_fk  = '0;
        w_fpc = '0;
        for (int i = 0; i < NSTAGES; i++) begin
            if (flush_req[i] && !w_stall[i+1]) begin
                w_fk  = KW'(i + 1);
                w_fpc = flush_pc[i*XLEN +: XLEN];
            end
        end
        for (int j = 0; j <= NSTAGES; j++)
            w_fmask[j] = (j >= 1) && (KW'(j) < w_fk);
    end

    assign w_accept = (w_fk != '0) && ((r_state == ST_RUN) || (w_fk > r_cur_k));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_RUN;
            r_cur_k          <= '0;
            r_cnt            <= '0;
            r_flush          <= '0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else if (w_accept) begin
            r_state          <= ST_FLUSH;
            r_cur_k          <= w_fk;
            r_cnt            <= FC_LOAD;
            r_flush          <= w_fmask;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= w_fpc;
        end else begin
            r_redirect_valid <= 1'b0;
            if (r_state == ST_FLUSH) begin
                if (r_cnt == 2'd0) begin
                    r_state <= ST_RUN;
                    r_flush <= '0;
                end else begin
                    r_cnt <= r_cnt - 2'd1;
                end
            end else begin
                r_flush <= '0;
            end
        end
    end

    assign flush          = r_flush;
    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

    generate
        if (STALL_TIMEOUT > 0) begin : g_wd
            localparam int WDW = $clog2(STALL_TIMEOUT + 1);
            logic [WDW-1:0] r_wd_cnt;
            logic           r_timeout;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wd_cnt  <= '0;
                    r_timeout <= 1'b0;
                end else if (w_stall[0] && !w_accept) begin
                    if (r_wd_cnt != WDW'(STALL_TIMEOUT)) r_wd_cnt <= r_wd_cnt + 1'b1;
                    if (r_wd_cnt >= WDW'(STALL_TIMEOUT - 1)) r_timeout <= 1'b1;
                end else begin
                    r_wd_cnt <= '0;
                end
            end
            assign stall_timeout = r_timeout;
        end else begin : g_no_wd
            assign stall_timeout = 1'b0;
        end
    endgenerate

`ifdef PIPE_CTRL_PERF_EN
    generate
        for (genvar g = 0; g < NSTAGES; g++) begin : g_perf
            logic [31:0] r_perf;
            always_ff @(posedge clk) begin
                if (rst)                     r_perf <= '0;
                else if (w_k == KW'(g + 1)) r_perf <= r_perf + 32'd1;
            end
            assign perf_stall_cnt[g*32 +: 32] = r_perf;
        end
    endgenerate
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// tb/tb_pipe_ctrl_gen.sv - directed and random checks of pipe_ctrl_gen against a reference model
module tb_pipe_ctrl_gen;
    localparam int N  = 5;
    localparam int X  = 32;
    localparam int FC = 3;
    localparam int TO = 8;
    localparam int SW = N + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   stallreq, flush_req;
    logic [N*X-1:0] flush_pc;
    logic [N:0]     stall, flush;
    logic           redirect_valid, stall_timeout;
    logic [X-1:0]   redirect_pc;
    logic [N*32-1:0] perf_stall_cnt;

    int checks = 0;
    int failures = 0;

    bit          m_in_flush;
    int          m_k, m_rem, m_wd;
    logic [N:0]  m_flush;
    logic        m_rv, m_to;
    logic [X-1:0] m_pc;
    logic [31:0] m_perf [N];

    pipe_ctrl_gen #(.NSTAGES(N), .XLEN(X), .FLUSH_CYCLES(FC), .STALL_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall_timeout(stall_timeout), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic int origin();
        int k = 0;
        for (int i = 0; i < N; i++) if (stallreq[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [N:0] exp_stall();
        int k = origin();
        if (rst || k == 0) return '0;
        return SW'((1 << (k + 1)) - 1);
    endfunction

    function automatic logic [N*32-1:0] exp_perf();
        logic [N*32-1:0] v = '0;
`ifdef PIPE_CTRL_PERF_EN
        for (int i = 0; i < N; i++) v[i*32 +: 32] = m_perf[i];
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stall", 256'(stall), 256'(exp_stall()));
        chk("flush", 256'(flush), 256'(m_flush));
        chk("redirect_valid", 256'(redirect_valid), 256'(m_rv));
        chk("redirect_pc", 256'(redirect_pc), 256'(m_pc));
        chk("stall_timeout", 256'(stall_timeout), 256'(m_to));
        chk("perf", 256'(perf_stall_cnt), 256'(exp_perf()));
    endtask

    task automatic model_edge();
        int k, w;
        bit acc;
        if (rst) begin
            m_in_flush = 0; m_k = 0; m_rem = 0; m_wd = 0;
            m_flush = '0; m_rv = 0; m_pc = '0; m_to = 0;
            for (int i = 0; i < N; i++) m_perf[i] = '0;
            return;
        end
        k = origin();
        w = 0;
        for (int i = 0; i < N; i++) if (flush_req[i] && k <= i) w = i + 1;
        acc = (w > 0) && (!m_in_flush || w > m_k);
        if (acc) begin
            m_in_flush = 1; m_k = w; m_rem = FC; m_rv = 1;
            m_flush = SW'((1 << w) - 2);
            m_pc = flush_pc[(w-1)*X +: X];
        end else begin
            m_rv = 0;
            if (m_in_flush) begin
                m_rem--;
                if (m_rem == 0) begin m_in_flush = 0; m_flush = '0; end
            end else m_flush = '0;
        end
        if (k > 0 && !acc) begin
            if (m_wd < TO) m_wd++;
            if (m_wd >= TO) m_to = 1;
        end else m_wd = 0;
        if (k > 0) m_perf[k-1] = m_perf[k-1] + 32'd1;
    endtask

    task automatic cycle();
        #1 check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; stallreq = '0; flush_req = '0;
        flush_pc = {$urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        cycle(); cycle();
        rst = 0;
        cycle();

        // zero-latency prefix stall
        stallreq = 5'b01000; #1 chk("t1_mem", 256'(stall), 256'(6'b011111)); cycle();
        stallreq = 5'b00110; #1 chk("t1_ex", 256'(stall), 256'(6'b001111)); cycle();
        stallreq = 5'b00000; #1 chk("t1_none", 256'(stall), 256'(6'b000000)); cycle();

        // single EX flush
        flush_pc[2*X +: X] = 32'h80; flush_req = 5'b00100; cycle();
        flush_req = '0;
        #1 chk("t2_flush", 256'(flush), 256'(6'b000110));
        chk("t2_rv", 256'(redirect_valid), 256'(1'b1));
        chk("t2_pc", 256'(redirect_pc), 256'(32'h80));
        cycle();
        chk("t2_rv_drop", 256'(redirect_valid), 256'(1'b0));
        repeat (4) cycle();

        // simultaneous requests, oldest wins
        flush_pc[3*X +: X] = 32'h200; flush_req = 5'b01100; cycle();
        flush_req = '0;
        #1 chk("t3_flush", 256'(flush), 256'(6'b001110));
        chk("t3_pc", 256'(redirect_pc), 256'(32'h200));
        repeat (4) cycle();

        // stalled requester waits
        stallreq = 5'b01000; flush_req = 5'b00100;
        repeat (3) cycle();
        chk("t4_noflush", 256'(flush), 256'(6'b0));
        stallreq = '0; cycle();
        flush_req = '0;
        #1 chk("t4_flush", 256'(flush), 256'(6'b000110));
        repeat (4) cycle();

        // watchdog
        #1 chk("t5_pre", 256'(stall_timeout), 256'(1'b0));
        stallreq = 5'b00001;
        repeat (8) cycle();
        stallreq = '0;
        #1 chk("t5_fire", 256'(stall_timeout), 256'(1'b1));
        cycle(); cycle();
        chk("t5_sticky", 256'(stall_timeout), 256'(1'b1));
        rst = 1; cycle(); rst = 0;
        #1 chk("t5_clear", 256'(stall_timeout), 256'(1'b0));

        // reset in second flush cycle
        flush_req = 5'b00100; cycle();
        flush_req = '0; cycle();
        rst = 1; cycle(); rst = 0;
        #1 chk("t6_flush", 256'(flush), 256'(6'b0));
        chk("t6_rv", 256'(redirect_valid), 256'(1'b0));
        cycle();
        chk("t6_rv_after", 256'(redirect_valid), 256'(1'b0));
        stallreq = 5'b00010;
        repeat (5) cycle();
        stallreq = '0;
`ifdef PIPE_CTRL_PERF_EN
        #1 chk("t6_perf1", 256'(perf_stall_cnt[32 +: 32]), 256'(32'd5));
`else
        #1 chk("t6_perf_off", 256'(perf_stall_cnt), 256'(0));
`endif
        cycle();

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                stallreq[i]  = ($urandom_range(0, 7) == 0);
                flush_req[i] = ($urandom_range(0, 5) == 0);
                flush_pc[i*X +: X] = $urandom;
            end
            rst = ($urandom_range(0, 60) == 0);
            cycle();
        end
        rst = 0; stallreq = '0; flush_req = '0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
